// File: rtl/step_ctrl_if.sv
// Debug command port and core-side signals of the run/step controller.
interface step_ctrl_if #(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [CNT_W-1:0]  cmd_arg;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] core_pc;
    logic              core_en;
    logic              halted;
    logic [1:0]        halt_cause;
    logic [31:0]       cycle_cnt;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cmd_addr, core_pc,
        input  cmd_ready, core_en, halted, halt_cause, cycle_cnt
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cmd_addr, core_pc,
        output cmd_ready, core_en, halted, halt_cause, cycle_cnt
    );
endinterface

// File: rtl/step_ctrl.sv
// Debug run/step controller: gates the core clock enable, counts steps,
// stops on a PC breakpoint and reports the halt cause.
module step_ctrl #(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    step_ctrl_if.slave  bus
);
    localparam logic [1:0] S_HALTED   = 2'd0;
    localparam logic [1:0] S_RUNNING  = 2'd1;
    localparam logic [1:0] S_STEPPING = 2'd2;

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_BRK  = 2'b11;

    localparam logic [1:0] C_RESET = 2'b00;
    localparam logic [1:0] C_HOST  = 2'b01;
    localparam logic [1:0] C_STEP  = 2'b10;
    localparam logic [1:0] C_BRK   = 2'b11;

    logic [1:0]        state;
    logic [CNT_W-1:0]  rem;
    logic [ADDR_W-1:0] brk_addr;
    logic              brk_en;
    logic              first;
    logic [1:0]        halt_cause;
    logic [31:0]       cycle_cnt;

    logic bp;
    logic core_en;
    logic cmd_ready;
    logic accept;

    // first masks the breakpoint on the resume cycle so a halt at the
    // breakpoint PC can be stepped past.
    assign bp        = brk_en & (bus.core_pc == brk_addr) & ~first;
    assign core_en   = (state != S_HALTED) & ~bp;
    assign cmd_ready = (state == S_HALTED) | (bus.cmd_op == OP_HALT);
    assign accept    = bus.cmd_valid & cmd_ready;

    assign bus.cmd_ready  = cmd_ready;
    assign bus.core_en    = core_en;
    assign bus.halted     = (state == S_HALTED);
    assign bus.halt_cause = halt_cause;
    assign bus.cycle_cnt  = cycle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_HALTED;
            rem        <= '0;
            brk_addr   <= '0;
            brk_en     <= 1'b0;
            first      <= 1'b0;
            halt_cause <= C_RESET;
            cycle_cnt  <= '0;
        end else begin
            if (core_en) begin
                cycle_cnt <= cycle_cnt + 32'd1;
                first     <= 1'b0;
            end
            if (state == S_HALTED) begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_RUN: begin
                            state <= S_RUNNING;
                            first <= 1'b1;
                        end
                        OP_STEP: begin
                            if (bus.cmd_arg != '0) begin
                                state <= S_STEPPING;
                                rem   <= bus.cmd_arg;
                                first <= 1'b1;
                            end
                        end
                        OP_BRK: begin
                            brk_addr <= bus.cmd_addr;
                            brk_en   <= bus.cmd_arg[0];
                        end
                        default: ;
                    endcase
                end
            end else begin
                // Exit priority: breakpoint, step exhaustion, host HALT.
                if (bp) begin
                    state      <= S_HALTED;
                    halt_cause <= C_BRK;
                end else if (state == S_STEPPING && core_en && rem == CNT_W'(1)) begin
                    state      <= S_HALTED;
                    halt_cause <= C_STEP;
                end else if (accept) begin
                    state      <= S_HALTED;
                    halt_cause <= C_HOST;
                end else if (state == S_STEPPING && core_en) begin
                    rem <= rem - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_step_ctrl.sv
// Directed table-driven bench for step_ctrl plus hand-written corner sequences.
module tb_step_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    step_ctrl_if #(.CNT_W(16), .ADDR_W(32)) bus ();

    step_ctrl #(.CNT_W(16), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [15:0] arg;
        logic [31:0] addr;
        logic [31:0] pc;
        logic        ready;
        logic        en;
        logic        halted;
        logic [1:0]  cause;
        logic [31:0] cnt;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(logic v, logic [1:0] op, logic [15:0] arg, logic [31:0] addr,
                                logic [31:0] pc, logic rdy, logic en, logic h,
                                logic [1:0] c, logic [31:0] n);
        vec_t r;
        r.valid = v;   r.op = op;   r.arg = arg; r.addr = addr; r.pc = pc;
        r.ready = rdy; r.en = en;   r.halted = h; r.cause = c;  r.cnt = n;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] arg,
                         input logic [31:0] addr, input logic [31:0] pc);
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        bus.cmd_addr  = addr;
        bus.core_pc   = pc;
    endtask

    initial begin
        // Columns: valid op arg addr pc | ready en halted cause cnt
        vecs[0]  = mk(0, 2'd1, 16'd0, 32'h0,  32'h00, 1, 0, 1, 2'd0, 0);
        vecs[1]  = mk(1, 2'd2, 16'd5, 32'h0,  32'h00, 1, 0, 1, 2'd0, 0);
        vecs[2]  = mk(0, 2'd1, 16'd0, 32'h0,  32'h00, 0, 1, 0, 2'd0, 0);
        vecs[3]  = mk(0, 2'd1, 16'd0, 32'h0,  32'h00, 0, 1, 0, 2'd0, 1);
        vecs[4]  = mk(0, 2'd1, 16'd0, 32'h0,  32'h00, 0, 1, 0, 2'd0, 2);
        vecs[5]  = mk(0, 2'd1, 16'd0, 32'h0,  32'h00, 0, 1, 0, 2'd0, 3);
        vecs[6]  = mk(0, 2'd1, 16'd0, 32'h0,  32'h00, 0, 1, 0, 2'd0, 4);
        vecs[7]  = mk(0, 2'd1, 16'd0, 32'h0,  32'h00, 1, 0, 1, 2'd2, 5);
        vecs[8]  = mk(1, 2'd3, 16'd1, 32'h20, 32'h00, 1, 0, 1, 2'd2, 5);
        vecs[9]  = mk(1, 2'd1, 16'd0, 32'h0,  32'h10, 1, 0, 1, 2'd2, 5);
        vecs[10] = mk(0, 2'd1, 16'd0, 32'h0,  32'h10, 0, 1, 0, 2'd2, 5);
        vecs[11] = mk(0, 2'd1, 16'd0, 32'h0,  32'h14, 0, 1, 0, 2'd2, 6);
        vecs[12] = mk(0, 2'd1, 16'd0, 32'h0,  32'h18, 0, 1, 0, 2'd2, 7);
        vecs[13] = mk(0, 2'd1, 16'd0, 32'h0,  32'h1c, 0, 1, 0, 2'd2, 8);
        vecs[14] = mk(0, 2'd1, 16'd0, 32'h0,  32'h20, 0, 0, 0, 2'd2, 9);
        vecs[15] = mk(0, 2'd1, 16'd0, 32'h0,  32'h20, 1, 0, 1, 2'd3, 9);
        vecs[16] = mk(1, 2'd2, 16'd1, 32'h0,  32'h20, 1, 0, 1, 2'd3, 9);
        vecs[17] = mk(0, 2'd1, 16'd0, 32'h0,  32'h20, 0, 1, 0, 2'd3, 9);
        vecs[18] = mk(0, 2'd1, 16'd0, 32'h0,  32'h24, 1, 0, 1, 2'd2, 10);
        vecs[19] = mk(1, 2'd2, 16'd3, 32'h0,  32'h18, 1, 0, 1, 2'd2, 10);
        vecs[20] = mk(0, 2'd1, 16'd0, 32'h0,  32'h18, 0, 1, 0, 2'd2, 10);
        vecs[21] = mk(0, 2'd1, 16'd0, 32'h0,  32'h1c, 0, 1, 0, 2'd2, 11);
        vecs[22] = mk(0, 2'd1, 16'd0, 32'h0,  32'h20, 0, 0, 0, 2'd2, 12);
        vecs[23] = mk(0, 2'd1, 16'd0, 32'h0,  32'h20, 1, 0, 1, 2'd3, 12);
        vecs[24] = mk(1, 2'd2, 16'd0, 32'h0,  32'h20, 1, 0, 1, 2'd3, 12);
        vecs[25] = mk(0, 2'd1, 16'd0, 32'h0,  32'h20, 1, 0, 1, 2'd3, 12);
        vecs[26] = mk(1, 2'd0, 16'd0, 32'h0,  32'h20, 1, 0, 1, 2'd3, 12);
        vecs[27] = mk(0, 2'd1, 16'd0, 32'h0,  32'h20, 1, 0, 1, 2'd3, 12);

        drive(0, 2'd1, '0, '0, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].op, vecs[i].arg, vecs[i].addr, vecs[i].pc);
            #1;
            chk($sformatf("v%0d.ready", i),  {31'd0, bus.cmd_ready}, {31'd0, vecs[i].ready});
            chk($sformatf("v%0d.en", i),     {31'd0, bus.core_en},   {31'd0, vecs[i].en});
            chk($sformatf("v%0d.halted", i), {31'd0, bus.halted},    {31'd0, vecs[i].halted});
            chk($sformatf("v%0d.cause", i),  {30'd0, bus.halt_cause}, {30'd0, vecs[i].cause});
            chk($sformatf("v%0d.cnt", i),    bus.cycle_cnt,          vecs[i].cnt);
        end

        // RUN, offer STEP while running (must stall), then host HALT.
        @(negedge clk);
        drive(1, 2'd1, 16'd0, 32'h0, 32'h100);
        #1 chk("run.ready", {31'd0, bus.cmd_ready}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1, 2'd2, 16'd7, 32'h0, 32'h100);
            #1;
            chk($sformatf("stall%0d.ready", i), {31'd0, bus.cmd_ready}, 32'd0);
            chk($sformatf("stall%0d.en", i),    {31'd0, bus.core_en},   32'd1);
        end
        @(negedge clk);
        drive(1, 2'd0, 16'd0, 32'h0, 32'h100);
        #1;
        chk("halt.ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("halt.en_accept_cycle", {31'd0, bus.core_en}, 32'd1);
        @(negedge clk);
        drive(0, 2'd1, 16'd0, 32'h0, 32'h100);
        #1;
        chk("halt.en_after", {31'd0, bus.core_en}, 32'd0);
        chk("halt.halted", {31'd0, bus.halted}, 32'd1);
        chk("halt.cause", {30'd0, bus.halt_cause}, 32'd1);
        chk("halt.cnt", bus.cycle_cnt, 32'd23);

        // Async reset in the middle of a long step.
        @(negedge clk);
        drive(1, 2'd2, 16'd100, 32'h0, 32'h200);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive(0, 2'd1, 16'd0, 32'h0, 32'h200);
            #1 chk($sformatf("step100.en%0d", i), {31'd0, bus.core_en}, 32'd1);
        end
        #2 rst = 1'b1;
        #1;
        chk("rst.en", {31'd0, bus.core_en}, 32'd0);
        chk("rst.cnt", bus.cycle_cnt, 32'd0);
        chk("rst.cause", {30'd0, bus.halt_cause}, 32'd0);
        chk("rst.halted", {31'd0, bus.halted}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Breakpoint must be disabled after reset even though pc matches reset brk_addr.
        @(negedge clk);
        drive(1, 2'd1, 16'd0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 2'd1, 16'd0, 32'h0, 32'h0);
            #1 chk($sformatf("nobrk.en%0d", i), {31'd0, bus.core_en}, 32'd1);
        end
        @(negedge clk);
        drive(1, 2'd0, 16'd0, 32'h0, 32'h0);
        @(negedge clk);
        drive(0, 2'd1, 16'd0, 32'h0, 32'h0);
        #1;
        chk("nobrk.cause", {30'd0, bus.halt_cause}, 32'd1);
        chk("nobrk.cnt", bus.cycle_cnt, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/step_ctrl.md
# step_ctrl

Debug run/step controller that gates the SoC core clock enable. A host or bench issues HALT/RUN/STEP/SET_BRK commands over a valid/ready port. The block sequences the core accordingly, counting steps, stopping on a PC breakpoint and reporting why it halted. It sits between the debug host and the `soc` core-enable input, so interactive sessions no longer need to free-run the clock a fixed number of times.

## Interface
- `CNT_W`, 16: width of step count argument
- `ADDR_W`, 32: width of PC and breakpoint address
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command can be accepted this cycle
- `cmd_op`  in  2  00 HALT, 01 RUN, 10 STEP, 11 SET_BRK
- `cmd_arg`  in  CNT_W  STEP: cycle count; SET_BRK: bit 0 = breakpoint enable
- `cmd_addr`  in  ADDR_W  SET_BRK: breakpoint address
- `core_pc`  in  ADDR_W  PC of the instruction the core executes on its next enabled cycle
- `core_en`  out  1  clock enable to core
- `halted`  out  1  controller in HALTED state
- `halt_cause`  out  2  00 reset, 01 host HALT, 10 step done, 11 breakpoint
- `cycle_cnt`  out  32  number of cycles with `core_en`=1; wraps modulo 2^32

## Operation
- States: HALTED, RUNNING, STEPPING. Registers: `rem` (CNT_W), `brk_addr`, `brk_en`, `first`, `halt_cause`, `cycle_cnt`.
- Reset values:
  - state HALTED
  - `halted`=1, `core_en`=0, `halt_cause`=00, `cycle_cnt`=0
  - `brk_en`=0, `brk_addr`=0, `rem`=0, `first`=0
- Accept = `cmd_valid & cmd_ready`.
- `cmd_ready` = (state==HALTED) | (`cmd_op`==HALT). It depends combinationally on `cmd_op` only. Non-HALT ops offered while not HALTED stall.
- `bp` = `brk_en` & (`core_pc`==`brk_addr`) & ~`first`.
- `core_en` = (state!=HALTED) & ~`bp`. It is combinational from registered state and `core_pc`.
- HALTED, accept RUN: state RUNNING, `first`=1.
- HALTED, accept STEP with `cmd_arg`=N:
  - N=0: no-op. State and `halt_cause` are unchanged.
  - N>0: state STEPPING, `rem`=N, `first`=1.
- HALTED, accept SET_BRK: `brk_addr`=`cmd_addr`, `brk_en`=`cmd_arg[0]`. State unchanged.
- HALTED, accept HALT: no effect.
- `first` clears on the first cycle with `core_en`=1. This lets execution resume past a breakpoint at the current PC.
- RUNNING/STEPPING, exit conditions, in priority order:
  1. `bp`: no enable this cycle; next state HALTED, cause 11.
  2. STEPPING with `core_en` and `rem`==1: next state HALTED, cause 10.
  3. Accepted HALT: next state HALTED, cause 01. `core_en` still follows the equation in the accept cycle.
- Lower-priority exits are dropped when a higher one fires. The cause reports only the winner.
- STEPPING with `core_en`=1 and no exit: `rem` decrements.
- `cycle_cnt` increments every cycle `core_en`=1.
- Async `rst` mid-operation forces `core_en`=0 immediately and restores all reset values. A step in progress is discarded.

## Timing
- RUN accepted at edge t → `core_en`=1 from cycle t+1 until an exit condition.
- STEP N accepted at edge t, no breakpoint:
  - `core_en`=1 in cycles t+1..t+N exactly
  - `halted`=1 and cause 10 from cycle t+N+1
- Breakpoint:
  - `core_en`=0 combinationally in the cycle `core_pc` matches
  - `halted`=1 the following cycle
- Host HALT accepted at t: `core_en`=0 from t+1.
- `halted` and `halt_cause` are registered, one cycle after the deciding edge.
- Zero-latency enable gating; no combinational path from `cmd_valid` to `core_en`.

## Test plan
- Reset then STEP `cmd_arg`=5 → `core_en` high exactly 5 cycles, `cycle_cnt`=5, `halted`=1, `halt_cause`=10.
- SET_BRK addr 0x20 en=1, RUN, `core_pc` advances 0x10,0x14,…,0x20 → `core_en`=0 in the 0x20 cycle, cause 11, `cycle_cnt`=4.
- From that breakpoint halt, STEP 1 with `core_pc`=0x20 → one enabled cycle (skip via `first`), cause 10.
- RUN, then HALT after 10 cycles; also offer STEP while RUNNING → STEP stalls (`cmd_ready`=0), HALT accepted, cause 01, `core_en` low next cycle.
- STEP 3 with breakpoint matching on the 3rd cycle → breakpoint wins, 2 enabled cycles, cause 11. STEP 0 while halted → no state change.
- Assert `rst` mid-STEP 100 at cycle 40 → `core_en` drops immediately, `cycle_cnt`=0, `halt_cause`=00, `brk_en`=0.
